// File: rtl/skidmem_rd_arbiter.sv
// Round-robin arbiter sharing one skidmem read port between N_REQ requesters.
// An in-order tag FIFO steers each returning word back to the requester that issued it.
module skidmem_rd_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 512,
    parameter int MAX_INFLIGHT = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(MAX_INFLIGHT + 1),
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ-1:0]    req_vld,
    output logic [N_REQ-1:0]    req_rdy,
    output logic [WIDTH-1:0]    rsp_dat,
    output logic [N_REQ-1:0]    rsp_vld,
    input  logic [N_REQ-1:0]    rsp_rdy,
    output logic [AW-1:0]       mem_rd_addr,
    output logic                mem_rd_req_vld,
    input  logic                mem_rd_req_rdy,
    input  logic [WIDTH-1:0]    mem_rd_dat,
    input  logic                mem_rd_dat_vld,
    output logic                mem_rd_dat_rdy,
    output logic [CW-1:0]       inflight,
    output logic                err
);

    localparam logic [IW:0]   NR    = (IW+1)'(N_REQ);
    localparam logic [CW-1:0] MAXC  = CW'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LASTP = PW'(MAX_INFLIGHT - 1);

    logic [IW-1:0] rr_q, rr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [IW-1:0] tag_q [MAX_INFLIGHT];

    logic [2*N_REQ-1:0] dbl;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      head;
    logic               any_vld;
    logic               has_space;
    logic               nonempty;
    logic               issue_fire;
    logic               rsp_fire;
    logic               head_rdy;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LASTP) ? '0 : p + 1'b1;
    endfunction

    // Rotate so bit 0 is the rr position; lowest set bit is the winner.
    always_comb begin
        dbl = {req_vld, req_vld} >> rr_q;
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) off = IW'(k);
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= NR) sum = sum - NR;
        grant = sum[IW-1:0];
    end

    assign any_vld   = |req_vld;
    assign has_space = (count_q < MAXC);
    assign nonempty  = (count_q != '0);
    assign head      = tag_q[rd_ptr_q];

    // Gated by rst so the request side is quiet while reset is held.
    assign mem_rd_req_vld = rst & any_vld & has_space;
    assign issue_fire     = mem_rd_req_vld & mem_rd_req_rdy;

    always_comb begin
        mem_rd_addr = '0;
        req_rdy     = '0;
        rsp_vld     = '0;
        head_rdy    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == IW'(i)) begin
                mem_rd_addr = req_addr[i*AW +: AW];
                req_rdy[i]  = issue_fire;
            end
            if (head == IW'(i)) begin
                head_rdy   = rsp_rdy[i];
                rsp_vld[i] = mem_rd_dat_vld & nonempty;
            end
        end
    end

    assign rsp_dat        = mem_rd_dat;
    assign mem_rd_dat_rdy = nonempty & head_rdy;
    assign rsp_fire       = mem_rd_dat_vld & mem_rd_dat_rdy;
    assign inflight       = count_q;
    assign err            = err_q;

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (mem_rd_dat_vld & ~nonempty);
        if (issue_fire) begin
            rr_d     = (sum + 1'b1 >= NR) ? '0 : grant + 1'b1;
            wr_ptr_d = bump(wr_ptr_q);
        end
        if (rsp_fire) rd_ptr_d = bump(rd_ptr_q);
        unique case ({issue_fire, rsp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (issue_fire) tag_q[wr_ptr_q] <= grant;
    end

endmodule

// File: tb/tb_skidmem_rd_arbiter.sv
// Bench for skidmem_rd_arbiter: behavioural memory, queue-based reference model,
// directed vectors with literal expectations and a random stall stress phase.
module tb_skidmem_rd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 512;
    localparam int MI = 8;
    localparam int AW = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [W-1:0]  rsp_dat, mem_rd_dat;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_req_vld, mem_rd_req_rdy;
    logic          mem_rd_dat_vld, mem_rd_dat_rdy;
    logic [CW-1:0] inflight;
    logic          err;

    logic          mq_vld;
    logic [W-1:0]  mq_dat;
    logic          force_vld;
    logic [W-1:0]  force_dat;
    logic          dat_stall;
    int            mem_lat;

    assign mem_rd_dat_vld = force_vld | mq_vld;
    assign mem_rd_dat     = force_vld ? force_dat : mq_dat;

    always #5 clk = ~clk;

    skidmem_rd_arbiter #(
        .N_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_vld(req_vld), .req_rdy(req_rdy),
        .rsp_dat(rsp_dat), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .mem_rd_addr(mem_rd_addr), .mem_rd_req_vld(mem_rd_req_vld),
        .mem_rd_req_rdy(mem_rd_req_rdy), .mem_rd_dat(mem_rd_dat),
        .mem_rd_dat_vld(mem_rd_dat_vld), .mem_rd_dat_rdy(mem_rd_dat_rdy),
        .inflight(inflight), .err(err)
    );

    typedef struct { logic [W-1:0] data; int due; } mq_t;
    typedef struct { int req; logic [W-1:0] data; } tag_t;

    mq_t          memq[$];
    tag_t         tq[$];
    int           grant_log[$];
    logic [W-1:0] rsp_log[$];
    int           rr_m = 0;
    bit           err_m = 0;
    int           cyc = 0;
    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        return W'(a) + 1000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_addr(input int i, input int a);
        req_addr[i*AW +: AW] = AW'(a);
    endtask

    always @(posedge clk) begin
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc && !dat_stall) begin
            mq_vld = 1'b1;
            mq_dat = memq[0].data;
        end else begin
            mq_vld = 1'b0;
            mq_dat = '0;
        end
    end

    always @(negedge clk) begin : compare
        int g;
        bit space, exp_vld, exp_pop;
        logic [N-1:0] exp_rdy, exp_rsp;
        logic exp_drdy;
        logic [AW-1:0] ga;
        if (!rst) begin
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_req_vld", mem_rd_req_vld, 0);
            chk("rst_dat_rdy", mem_rd_dat_rdy, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_err", err, 0);
            tq.delete();
            memq.delete();
            rr_m  = 0;
            err_m = 0;
        end else begin
            space = tq.size() < MI;
            g = 0;
            for (int k = N - 1; k >= 0; k--) begin
                if (req_vld[(rr_m + k) % N]) g = (rr_m + k) % N;
            end
            exp_vld = (|req_vld) && space;
            exp_rdy = '0;
            if (exp_vld && mem_rd_req_rdy) exp_rdy[g] = 1'b1;
            ga = req_addr[g*AW +: AW];
            exp_rsp  = '0;
            exp_drdy = 1'b0;
            if (tq.size() > 0) begin
                exp_drdy = rsp_rdy[tq[0].req];
                if (mem_rd_dat_vld) exp_rsp[tq[0].req] = 1'b1;
            end
            chk("mem_rd_req_vld", mem_rd_req_vld, exp_vld);
            chk("req_rdy", req_rdy, exp_rdy);
            if (exp_vld) chk("mem_rd_addr", mem_rd_addr, ga);
            chk("rsp_vld", rsp_vld, exp_rsp);
            chk("mem_rd_dat_rdy", mem_rd_dat_rdy, exp_drdy);
            chk("inflight", inflight, tq.size());
            chk("err", err, err_m);
            exp_pop = mem_rd_dat_vld && exp_drdy;
            if (mem_rd_dat_vld && tq.size() == 0) err_m = 1;
            if (exp_pop) begin
                chk("rsp_dat", rsp_dat, tq[0].data);
                rsp_log.push_back(rsp_dat);
                void'(tq.pop_front());
            end
            if (exp_vld && mem_rd_req_rdy) begin
                tq.push_back('{g, mem_word(ga)});
                grant_log.push_back(g);
                rr_m = (g + 1) % N;
            end
            if (mq_vld && mem_rd_dat_rdy) void'(memq.pop_front());
            if (mem_rd_req_vld && mem_rd_req_rdy)
                memq.push_back('{mem_word(mem_rd_addr), cyc + mem_lat});
        end
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_vld = '0; req_addr = '0; rsp_rdy = '1;
        mem_rd_req_rdy = 1'b1; force_vld = 1'b0; force_dat = '0;
        dat_stall = 1'b0; mem_lat = 2; mq_vld = 1'b0; mq_dat = '0;
        tick(3);
        rst = 1'b1;
        tick(5);
        chk("t1_req_vld", mem_rd_req_vld, 0);
        chk("t1_inflight", inflight, 0);
        chk("t1_err", err, 0);

        set_addr(0, 10); set_addr(1, 20); set_addr(2, 30); set_addr(3, 40);
        grant_log.delete(); rsp_log.delete();
        req_vld = 4'hF;
        tick(12);
        req_vld = '0;
        tick(8);
        chk("t2_ngrant", grant_log.size(), 12);
        chk("t2_nrsp", rsp_log.size(), 12);
        if (grant_log.size() >= 8)
            for (int i = 0; i < 8; i++) chk("t2_grant", grant_log[i], i % 4);
        if (rsp_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t2_rsp", rsp_log[i], 1010 + 10 * i);

        req_vld = 4'hF;
        tick(5);
        #1 rst = 1'b0;
        #1;
        chk("t1_async_req_rdy", req_rdy, 0);
        chk("t1_async_rsp_vld", rsp_vld, 0);
        chk("t1_async_req_vld", mem_rd_req_vld, 0);
        chk("t1_async_dat_rdy", mem_rd_dat_rdy, 0);
        chk("t1_async_inflight", inflight, 0);
        chk("t1_async_err", err, 0);
        tick(2);
        grant_log.delete();
        rst = 1'b1;
        tick(3);
        chk("t1_ngrant", grant_log.size(), 3);
        if (grant_log.size() > 0) chk("t1_first_grant", grant_log[0], 0);
        req_vld = '0;
        tick(8);

        set_addr(1, 50);
        rsp_rdy = 4'b1101;
        grant_log.delete(); rsp_log.delete();
        req_vld = 4'b0010;
        tick(15);
        chk("t3_inflight", inflight, 8);
        chk("t3_req_rdy", req_rdy, 0);
        chk("t3_req_vld", mem_rd_req_vld, 0);
        chk("t3_ngrant", grant_log.size(), 8);
        rsp_rdy = '1;
        #1;
        chk("t3_still_full", req_rdy, 0);
        tick(1);
        chk("t3_resume", req_rdy, 4'b0010);
        tick(2);
        req_vld = '0;
        tick(16);
        chk("t3_ngrant2", grant_log.size(), 10);
        chk("t3_nrsp", rsp_log.size(), 10);
        for (int i = 0; i < rsp_log.size(); i++) chk("t3_rsp", rsp_log[i], 1050);
        chk("t3_drained", inflight, 0);

        rsp_rdy = 4'b1011;
        grant_log.delete(); rsp_log.delete();
        set_addr(0, 11); req_vld = 4'b0001; tick(1);
        set_addr(2, 22); req_vld = 4'b0100; tick(1);
        set_addr(0, 13); req_vld = 4'b0001; tick(1);
        req_vld = '0;
        tick(8);
        chk("t4_ngrant", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("t4_g0", grant_log[0], 0);
            chk("t4_g1", grant_log[1], 2);
            chk("t4_g2", grant_log[2], 0);
        end
        chk("t4_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() > 0) chk("t4_rsp0", rsp_log[0], 1011);
        chk("t4_inflight", inflight, 2);
        chk("t4_stall", mem_rd_dat_rdy, 0);
        rsp_rdy = '1;
        tick(6);
        chk("t4_nrsp2", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("t4_rsp1", rsp_log[1], 1022);
            chk("t4_rsp2", rsp_log[2], 1013);
        end

        chk("t5_err_pre", err, 0);
        force_dat = 32'hDEAD;
        force_vld = 1'b1;
        tick(1);
        force_vld = 1'b0;
        chk("t5_err_set", err, 1);
        tick(5);
        chk("t5_err_hold", err, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_err_clear", err, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        mem_lat = 5;
        set_addr(3, 77);
        req_vld = 4'b1000;
        tick(10);
        for (int i = 0; i < 20; i++) begin
            chk("t6_inflight", inflight, 5);
            tick(1);
        end
        req_vld = '0;
        tick(12);
        mem_lat = 2;

        for (int c = 0; c < 10000; c++) begin
            req_vld = N'($urandom);
            for (int i = 0; i < N; i++) set_addr(i, $urandom_range(0, D - 1));
            rsp_rdy = N'($urandom);
            mem_rd_req_rdy = ($urandom_range(0, 3) != 0);
            dat_stall = ($urandom_range(0, 3) == 0);
            mem_lat = $urandom_range(1, 4);
            tick(1);
        end
        req_vld = '0; rsp_rdy = '1; mem_rd_req_rdy = 1'b1; dat_stall = 1'b0;
        begin
            int w = 0;
            while (inflight != 0 && w < 200) begin
                tick(1);
                w++;
            end
        end
        chk("drain_inflight", inflight, 0);
        chk("drain_err", err, 0);
        chk("drain_model", tq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
